dec_lut_encoder12bits_clk: RTL and testbench

Sequential encoder that produces the 25-bit codeword W for a 12-bit index N. It is the transmit-side counterpart of the DEC_LUT 12-bit clocked decoder, which searches its table for W and returns N with found. The codeword is W = N*N, zero-extended to W_BITS, and is computed by an iterative shift-add multiplier with a start/valid/ack handshake. The block generates stimulus for the decoder and closes the encode->decode loop in system tests.

---
 rtl/dec_lut_encoder12bits_clk.sv | 128 ++++++++++++
 tb/tb_dec_lut_encoder12bits_clk.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dec_lut_encoder12bits_clk.sv
// ---------------------------------------------------------------------------
// dec_lut_encoder12bits_clk
//
// Sequential encoder producing the codeword W = N*N (zero-extended to W_BITS)
// for a D_BITS-wide index N, using an iterative shift-add multiplier. It is the
// transmit-side counterpart of the DEC_LUT clocked decoder and feeds its
// stimulus in encode->decode loopback tests.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   encode request, accepted only while ready=1
//   N_in   in   index to encode, sampled on the accepting edge
//   ack    in   consumer has taken W, honoured only while valid=1
//   ready  out  high in IDLE only
//   busy   out  high in CALC only
//   valid  out  high in DONE only; W stable while high
//   W      out  codeword N*N, zero-extended
//
// Latency is fixed: accept edge + D_BITS CALC edges, with no early exit,
// so every N (including 0) takes the same number of cycles.
// ---------------------------------------------------------------------------
module dec_lut_encoder12bits_clk #(
    parameter int unsigned D_BITS = 12,
    parameter int unsigned W_BITS = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [D_BITS-1:0]   N_in,
    input  logic                ack,
    output logic                ready,
    output logic                busy,
    output logic                valid,
    output logic [W_BITS-1:0]   W
);

    localparam int unsigned AW = 2 * D_BITS;
    localparam int unsigned CW = $clog2(D_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [D_BITS-1:0]   mcand_q,  mcand_d;
    logic [D_BITS-1:0]   mplier_q, mplier_d;
    logic [AW-1:0]       acc_q,    acc_d;
    logic [CW-1:0]       cnt_q,    cnt_d;
    logic [W_BITS-1:0]   w_q,      w_d;

    logic [AW-1:0]       partial;
    logic [AW-1:0]       acc_step;

    // One shift-add step: add the multiplicand weighted by the current bit
    // position when the multiplier LSB is set.
    always_comb begin
        partial  = AW'(mcand_q) << cnt_q;
        acc_step = mplier_q[0] ? (acc_q + partial) : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        w_d      = w_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = N_in;
                    mplier_d = N_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Last step: W takes the post-step accumulator on this same edge.
                if (cnt_q == CW'(D_BITS - 1)) begin
                    w_d     = W_BITS'(acc_step);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            w_q      <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
        end
    end

    always_comb begin
        ready = (state_q == S_IDLE);
        busy  = (state_q == S_CALC);
        valid = (state_q == S_DONE);
        W     = w_q;
    end

endmodule

// File: tb/tb_dec_lut_encoder12bits_clk.sv
// ---------------------------------------------------------------------------
// tb_dec_lut_encoder12bits_clk
//
// Self-checking bench for dec_lut_encoder12bits_clk: table of indices with
// hand-computed squares, plus hand-written sequences for start/ack ignoring,
// mid-calculation reset, input changes during CALC and a decoder loopback.
// ---------------------------------------------------------------------------
module tb_dec_lut_encoder12bits_clk;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] N_in;
    logic        ack;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [24:0] W;

    int n_checks = 0;
    int n_fail   = 0;

    dec_lut_encoder12bits_clk #(
        .D_BITS(12),
        .W_BITS(25)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .N_in  (N_in),
        .ack   (ack),
        .ready (ready),
        .busy  (busy),
        .valid (valid),
        .W     (W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] n;
        logic [24:0] w_exp;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference decoder: search the square table for w.
    function automatic logic [12:0] ref_decode(input logic [24:0] w);
        for (int i = 0; i < 4096; i++) begin
            if (i * i == int'(w)) return {1'b1, 12'(i)};
        end
        return 13'd0;
    endfunction

    // Accept n, wait for valid (bounded), hold DONE for `hold` cycles with
    // W stability checks, then optionally ack. scramble drives N_in, ack and
    // start with junk during CALC; all of it must be ignored.
    task automatic encode(input logic [11:0] n, input int hold, input bit scramble,
                          input bit do_ack, output logic [24:0] w_out, output int lat);
        int guard;
        guard = 0;
        while (!ready && guard < 40) begin
            @(posedge clk); @(negedge clk); guard++;
        end
        chk("ready_before_start", ready, 1'b1);
        start = 1'b1;
        N_in  = n;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!valid && lat < 40) begin
            chk("onehot_calc", {ready, busy, valid}, 3'b010);
            if (scramble) begin
                N_in  = 12'($urandom);
                ack   = ~ack;
                start = 1'b1;
            end
            @(posedge clk); lat++; @(negedge clk);
        end
        start = 1'b0;
        ack   = 1'b0;
        N_in  = 12'd0;
        chk("latency", 64'(lat), 64'd12);
        chk("onehot_done", {ready, busy, valid}, 3'b001);
        w_out = W;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            chk("w_stable", W, w_out);
            chk("valid_hold", valid, 1'b1);
        end
        if (do_ack) begin
            ack = 1'b1;
            @(posedge clk); @(negedge clk);
            ack = 1'b0;
            chk("ack_to_idle", {ready, busy, valid}, 3'b100);
            chk("w_kept_in_idle", W, w_out);
        end
    endtask

    vec_t        vecs[7];
    logic [24:0] w_got;
    int          lat;
    logic [12:0] dec;

    initial begin
        vecs[0] = '{12'd4095, 25'd16769025, 5};
        vecs[1] = '{12'd0,    25'd0,        0};
        vecs[2] = '{12'd1,    25'd1,        0};
        vecs[3] = '{12'd2048, 25'd4194304,  1};
        vecs[4] = '{12'd3000, 25'd9000000,  0};
        vecs[5] = '{12'd4094, 25'd16760836, 2};
        vecs[6] = '{12'd1234, 25'd1522756,  0};

        rst_n = 1'b0; start = 1'b0; ack = 1'b0; N_in = 12'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", {ready, busy, valid}, 3'b100);
        chk("reset_w", W, 25'd0);
        rst_n = 1'b1;

        // Ack in IDLE has no effect.
        ack = 1'b1;
        @(posedge clk); @(negedge clk);
        ack = 1'b0;
        chk("ack_in_idle", {ready, busy, valid}, 3'b100);

        foreach (vecs[i]) begin
            encode(vecs[i].n, vecs[i].hold, 1'b0, 1'b1, w_got, lat);
            chk($sformatf("w_n%0d", vecs[i].n), w_got, vecs[i].w_exp);
            chk("w_msb_zero", w_got[24], 1'b0);
        end

        // Junk on N_in/start/ack throughout CALC.
        encode(12'd1234, 0, 1'b1, 1'b1, w_got, lat);
        chk("w_scrambled_1234", w_got, 25'd1522756);

        // Start together with ack in DONE: leave to IDLE, no new computation.
        encode(12'd5, 0, 1'b1, 1'b0, w_got, lat);
        chk("w_n5", w_got, 25'd25);
        start = 1'b1; N_in = 12'd7; ack = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; ack = 1'b0;
        chk("done_start_ack", {ready, busy, valid}, 3'b100);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("no_second_calc", {ready, busy, valid}, 3'b100);
        end
        chk("w_after_ignored_start", W, 25'd25);

        // Reset at CALC cycle 6 discards the partial result.
        start = 1'b1; N_in = 12'd3000;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("busy_before_rst", busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk("midcalc_rst_flags", {ready, busy, valid}, 3'b100);
        chk("midcalc_rst_w", W, 25'd0);
        encode(12'd3000, 0, 1'b0, 1'b1, w_got, lat);
        chk("w_after_rst_3000", w_got, 25'd9000000);

        // Loopback through a reference decoder.
        begin
            logic [11:0] sweep[4];
            sweep = '{12'd4095, 12'd4094, 12'd1, 12'd0};
            foreach (sweep[i]) begin
                encode(sweep[i], 0, 1'b0, 1'b1, w_got, lat);
                dec = ref_decode(w_got);
                chk($sformatf("loop_found_%0d", sweep[i]), dec[12], 1'b1);
                chk($sformatf("loop_n_%0d", sweep[i]), dec[11:0], sweep[i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
